// File: rtl/m26_rx_pkg.sv
// m26_rx_pkg
// Shared definitions for the Mimosa26 receive arbiter: default header byte,
// bit positions inside the 32-bit readout word, the per-channel ingest state
// and a helper that assembles one readout word.
// No ports (package).
package m26_rx_pkg;

  localparam logic [7:0] M26_HEADER_DEFAULT = 8'h20;

  // Field offsets inside the 32-bit readout word
  localparam int CH_ID_LSB  = 20;
  localparam int FS_BIT     = 16;
  localparam int RESYNC_LSB = 17;

  typedef enum logic {
    ACCEPT,
    DISCARD
  } ch_state_t;

  // {header, channel id, resync marker, frame start, data}
  function automatic logic [31:0] pack_word(input logic [7:0]  header,
                                            input logic [3:0]  ch_id,
                                            input logic        resync,
                                            input logic        fs,
                                            input logic [15:0] data);
    logic [31:0] w;
    w = '0;
    w[31:24] = header;
    w[CH_ID_LSB +: 4] = ch_id;
    w[RESYNC_LSB +: 3] = {3{resync}};
    w[FS_BIT] = fs;
    w[15:0] = data;
    return w;
  endfunction

endpackage

// File: rtl/m26_rx_arbiter_if.sv
// m26_rx_arbiter_if
// Bundles the channel-side and readout-side signals of the arbiter.
//   CH_ENABLE/CH_WRITE/CH_FRAME_START [NUM_CH]  per-channel ingest controls
//   CH_DATA [16*NUM_CH]                         channel i at [16*i+15:16*i]
//   FIFO_FULL                                   downstream almost-full
//   FIFO_WRITE / FIFO_DATA[31:0]                tagged output word
//   LOST [NUM_CH] / LOST_CLR                    sticky overflow flags + clear
//   LOST_CNT [8*NUM_CH]                         only with M26_RX_ARBITER_LOST_CNT_EN
// Modports: master = channel/readout side driving the arbiter,
//           slave  = the arbiter itself.
interface m26_rx_arbiter_if #(
  parameter int NUM_CH = 6
);

  logic [NUM_CH-1:0]    CH_ENABLE;
  logic [NUM_CH-1:0]    CH_WRITE;
  logic [NUM_CH-1:0]    CH_FRAME_START;
  logic [16*NUM_CH-1:0] CH_DATA;
  logic                 FIFO_FULL;
  logic                 FIFO_WRITE;
  logic [31:0]          FIFO_DATA;
  logic [NUM_CH-1:0]    LOST;
  logic                 LOST_CLR;

`ifdef M26_RX_ARBITER_LOST_CNT_EN
  logic [8*NUM_CH-1:0]  LOST_CNT;

  modport master (
    output CH_ENABLE, CH_WRITE, CH_FRAME_START, CH_DATA, FIFO_FULL, LOST_CLR,
    input  FIFO_WRITE, FIFO_DATA, LOST, LOST_CNT
  );

  modport slave (
    input  CH_ENABLE, CH_WRITE, CH_FRAME_START, CH_DATA, FIFO_FULL, LOST_CLR,
    output FIFO_WRITE, FIFO_DATA, LOST, LOST_CNT
  );
`else
  modport master (
    output CH_ENABLE, CH_WRITE, CH_FRAME_START, CH_DATA, FIFO_FULL, LOST_CLR,
    input  FIFO_WRITE, FIFO_DATA, LOST
  );

  modport slave (
    input  CH_ENABLE, CH_WRITE, CH_FRAME_START, CH_DATA, FIFO_FULL, LOST_CLR,
    output FIFO_WRITE, FIFO_DATA, LOST
  );
`endif

endinterface

// File: rtl/m26_rx_arb_buf.sv
// m26_rx_arb_buf
// Small per-channel elastic buffer (synchronous FIFO, show-ahead read).
//   clk, rst_n      clock, asynchronous active-low reset (empties the buffer)
//   push, din       write one word when not full
//   pop, dout       dout is the oldest word; pop removes it when not empty
//   full, empty     status, valid before this cycle's push/pop
module m26_rx_arb_buf #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/m26_rx_arbiter.sv
// m26_rx_arbiter
// Merges NUM_CH Mimosa26 receive streams into one tagged 32-bit word stream.
// Each channel has an elastic buffer; a round-robin scheduler drains one
// word per cycle. After a buffer overflow the rest of the frame is discarded
// until the next frame start, so the readout never sees a silently truncated
// frame.
//   CLK_RX   receive clock
//   RST_N    asynchronous active-low reset
//   bus      m26_rx_arbiter_if.slave (channel inputs, readout outputs, LOST)
// Optional build macro M26_RX_ARBITER_LOST_CNT_EN: adds LOST_CNT (8-bit
// saturating per-channel drop counters) and marks the frame-start word that
// ends a discard period with bits [19:17]=3'b111.
module m26_rx_arbiter
  import m26_rx_pkg::*;
#(
  parameter int          NUM_CH = 6,
  parameter int          DEPTH  = 8,
  parameter logic [7:0]  HEADER = M26_HEADER_DEFAULT
) (
  input logic             CLK_RX,
  input logic             RST_N,
  m26_rx_arbiter_if.slave bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SW   = CH_W + 1;
`ifdef M26_RX_ARBITER_LOST_CNT_EN
  localparam int BUF_W = 18;
`else
  localparam int BUF_W = 17;
`endif

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [BUF_W-1:0]  buf_din  [NUM_CH];
  logic [BUF_W-1:0]  buf_dout [NUM_CH];

  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_valid;
  logic [SW-1:0]     cand;
  logic [BUF_W-1:0]  sel_word;
  logic              sel_resync;
  logic              fifo_write_q;
  logic [31:0]       fifo_data_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_t   state;
    logic        wr;
    logic        fs;
    logic [15:0] data;
    logic        ovf;
    logic        resync;
    logic        lost_q;

    assign wr   = bus.CH_WRITE[i] & bus.CH_ENABLE[i];
    assign fs   = bus.CH_FRAME_START[i];
    assign data = bus.CH_DATA[16*i +: 16];

    // Full is the pre-pop status, so a full buffer drops even if it is being
    // drained in the same cycle. DISCARD only accepts a new frame start.
    assign push[i] = wr && !full[i] && ((state == ACCEPT) || fs);
    assign ovf     = wr && full[i] && (state == ACCEPT);
    assign resync  = wr && fs && !full[i] && (state == DISCARD);

`ifdef M26_RX_ARBITER_LOST_CNT_EN
    assign buf_din[i] = {resync, fs, data};
`else
    assign buf_din[i] = {fs, data};
`endif

    m26_rx_arb_buf #(
      .DEPTH (DEPTH),
      .WIDTH (BUF_W)
    ) u_buf (
      .clk   (CLK_RX),
      .rst_n (RST_N),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (buf_din[i]),
      .dout  (buf_dout[i]),
      .full  (full[i]),
      .empty (empty[i])
    );

    assign pop[i] = grant_valid && (grant_idx == CH_W'(i));

    // Ingest state and sticky overflow flag; an overflow beats LOST_CLR
    always_ff @(posedge CLK_RX or negedge RST_N) begin
      if (!RST_N) begin
        state  <= ACCEPT;
        lost_q <= 1'b0;
      end else begin
        if (ovf) begin
          state <= DISCARD;
        end else if (resync) begin
          state <= ACCEPT;
        end
        if (ovf) begin
          lost_q <= 1'b1;
        end else if (bus.LOST_CLR) begin
          lost_q <= 1'b0;
        end
      end
    end

    assign bus.LOST[i] = lost_q;

`ifdef M26_RX_ARBITER_LOST_CNT_EN
    logic       cnt_evt;
    logic [7:0] cnt_q;

    // Counts the overflow itself and every frame start refused while full
    assign cnt_evt = wr && full[i] && ((state == ACCEPT) || fs);

    always_ff @(posedge CLK_RX or negedge RST_N) begin
      if (!RST_N) begin
        cnt_q <= 8'd0;
      end else if (cnt_evt) begin
        if (bus.LOST_CLR) begin
          cnt_q <= 8'd1;
        end else if (cnt_q != 8'hFF) begin
          cnt_q <= cnt_q + 8'd1;
        end
      end else if (bus.LOST_CLR) begin
        cnt_q <= 8'd0;
      end
    end

    assign bus.LOST_CNT[8*i +: 8] = cnt_q;
`endif
  end

  // Round-robin search starting one past the last granted channel
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr;
    cand        = '0;
    if (!bus.FIFO_FULL) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        cand = {1'b0, rr_ptr} + SW'(k);
        if (cand >= SW'(NUM_CH)) begin
          cand = cand - SW'(NUM_CH);
        end
        if (!grant_valid && !empty[cand[CH_W-1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = cand[CH_W-1:0];
        end
      end
    end
  end

  assign sel_word = buf_dout[grant_idx];
`ifdef M26_RX_ARBITER_LOST_CNT_EN
  assign sel_resync = sel_word[17];
`else
  assign sel_resync = 1'b0;
`endif

  // Registered output word; FIFO_DATA keeps its last value when idle
  always_ff @(posedge CLK_RX or negedge RST_N) begin
    if (!RST_N) begin
      fifo_write_q <= 1'b0;
      fifo_data_q  <= '0;
      rr_ptr       <= CH_W'(NUM_CH - 1);
    end else begin
      fifo_write_q <= grant_valid;
      if (grant_valid) begin
        fifo_data_q <= pack_word(HEADER, 4'(grant_idx), sel_resync,
                                 sel_word[16], sel_word[15:0]);
        rr_ptr      <= grant_idx;
      end
    end
  end

  assign bus.FIFO_WRITE = fifo_write_q;
  assign bus.FIFO_DATA  = fifo_data_q;

endmodule

// File: tb/tb_m26_rx_arbiter.sv
// tb_m26_rx_arbiter
// Directed bench for m26_rx_arbiter (NUM_CH=6, DEPTH=8, HEADER=8'h20):
// single frame latency, round-robin order, backpressure, overflow/discard,
// enable and LOST clear, asynchronous reset. Works with or without
// M26_RX_ARBITER_LOST_CNT_EN.
module tb_m26_rx_arbiter;

  localparam int NUM_CH = 6;
  localparam int DEPTH  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  m26_rx_arbiter_if #(.NUM_CH(NUM_CH)) bus ();

  m26_rx_arbiter #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .HEADER (8'h20)
  ) dut (
    .CLK_RX (clk),
    .RST_N  (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int ch, input logic fs, input logic [15:0] data);
    bus.CH_WRITE[ch]           = 1'b1;
    bus.CH_FRAME_START[ch]     = fs;
    bus.CH_DATA[16*ch +: 16]   = data;
  endtask

  task automatic clear_writes();
    bus.CH_WRITE       = '0;
    bus.CH_FRAME_START = '0;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic expect_word(input string tag, input logic [31:0] expected);
    check_output({tag, " valid"}, {31'b0, bus.FIFO_WRITE}, 32'd1);
    check_output({tag, " data"}, bus.FIFO_DATA, expected);
  endtask

  task automatic expect_idle(input string tag);
    check_output({tag, " idle"}, {31'b0, bus.FIFO_WRITE}, 32'd0);
  endtask

  function automatic logic [31:0] word_of(input int ch, input logic fs, input logic [15:0] d);
    return {8'h20, 4'(ch), 3'b000, fs, d};
  endfunction

  function automatic logic [15:0] rr_data(input int ch, input int k);
    return 16'((ch + 1) * 16'h1000 + k);
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.CH_ENABLE      = '1;
    bus.CH_WRITE       = '0;
    bus.CH_FRAME_START = '0;
    bus.CH_DATA        = '0;
    bus.FIFO_FULL      = 1'b0;
    bus.LOST_CLR       = 1'b0;

    // Reset values
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_idle("reset");
    check_output("reset data", bus.FIFO_DATA, 32'h0);
    check_output("reset lost", 32'(bus.LOST), 32'h0);
    #3 rst_n = 1'b1;
    tick();

    // Round robin: preload ch0..2 with 3 words each while held off
    bus.FIFO_FULL = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++) apply_stimulus(c, 1'b0, rr_data(c, k));
      tick();
    end
    clear_writes();
    tick();
    expect_idle("rr held");
    bus.FIFO_FULL = 1'b0;
    for (int n = 0; n < 9; n++) begin
      tick();
      expect_word($sformatf("rr word %0d", n), word_of(n % 3, 1'b0, rr_data(n % 3, n / 3)));
    end
    tick();
    expect_idle("rr done");

    // Single-channel frame, two-cycle latency
    apply_stimulus(0, 1'b1, 16'hAAAA);
    tick();
    expect_idle("t1 latency");
    apply_stimulus(0, 1'b0, 16'h0001);
    tick();
    expect_word("t1 w0", 32'h2001AAAA);
    apply_stimulus(0, 1'b0, 16'h0002);
    tick();
    expect_word("t1 w1", 32'h20000001);
    apply_stimulus(0, 1'b0, 16'h0003);
    tick();
    expect_word("t1 w2", 32'h20000002);
    clear_writes();
    tick();
    expect_word("t1 w3", 32'h20000003);
    tick();
    expect_idle("t1 end");
    check_output("t1 hold", bus.FIFO_DATA, 32'h20000003);

    // Backpressure on ch1: FULL sampled high for 5 edges
    apply_stimulus(1, 1'b0, 16'hB000);
    tick();
    expect_idle("bp first");
    apply_stimulus(1, 1'b0, 16'hB001);
    tick();
    expect_word("bp w0", word_of(1, 1'b0, 16'hB000));
    bus.FIFO_FULL = 1'b1;
    apply_stimulus(1, 1'b0, 16'hB002);
    tick();
    expect_idle("bp full 0");
    apply_stimulus(1, 1'b0, 16'hB003);
    tick();
    expect_idle("bp full 1");
    clear_writes();
    for (int n = 2; n < 5; n++) begin
      tick();
      expect_idle($sformatf("bp full %0d", n));
    end
    bus.FIFO_FULL = 1'b0;
    tick();
    expect_word("bp w1", word_of(1, 1'b0, 16'hB001));
    tick();
    expect_word("bp w2", word_of(1, 1'b0, 16'hB002));
    tick();
    expect_word("bp w3", word_of(1, 1'b0, 16'hB003));
    tick();
    expect_idle("bp end");

    // Overflow on ch0: DEPTH+3 words while held off, then a new frame start
    bus.FIFO_FULL = 1'b1;
    for (int k = 0; k < DEPTH + 3; k++) begin
      apply_stimulus(0, (k == 0), 16'(16'h0100 + k));
      tick();
    end
    clear_writes();
    expect_idle("ovf held");
    check_output("ovf lost", 32'(bus.LOST), 32'h1);
`ifdef M26_RX_ARBITER_LOST_CNT_EN
    check_output("ovf cnt", 32'(bus.LOST_CNT[7:0]), 32'd1);
`endif
    bus.FIFO_FULL = 1'b0;
    tick();
    expect_word("ovf w0", word_of(0, 1'b1, 16'h0100));
    apply_stimulus(0, 1'b1, 16'hBEEF);
    tick();
    clear_writes();
    expect_word("ovf w1", word_of(0, 1'b0, 16'h0101));
    for (int k = 2; k < DEPTH; k++) begin
      tick();
      expect_word($sformatf("ovf w%0d", k), word_of(0, 1'b0, 16'(16'h0100 + k)));
    end
    tick();
`ifdef M26_RX_ARBITER_LOST_CNT_EN
    expect_word("ovf resync", 32'h200FBEEF);
`else
    expect_word("ovf resync", 32'h2001BEEF);
`endif
    tick();
    expect_idle("ovf end");

    // Disabled channel is ignored, LOST_CLR clears the flag
    bus.CH_ENABLE = 6'b111011;
    apply_stimulus(2, 1'b0, 16'h2222);
    apply_stimulus(3, 1'b0, 16'h3333);
    tick();
    clear_writes();
    expect_idle("en first");
    tick();
    expect_word("en ch3", word_of(3, 1'b0, 16'h3333));
    tick();
    expect_idle("en no ch2");
    bus.CH_ENABLE = '1;
    check_output("clr before", 32'(bus.LOST), 32'h1);
    bus.LOST_CLR = 1'b1;
    tick();
    bus.LOST_CLR = 1'b0;
    check_output("clr lost", 32'(bus.LOST), 32'h0);
`ifdef M26_RX_ARBITER_LOST_CNT_EN
    check_output("clr cnt", 32'(bus.LOST_CNT[7:0]), 32'd0);
`endif

    // Fill ch4 exactly, then overflow in the same cycle as LOST_CLR
    bus.FIFO_FULL = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      apply_stimulus(4, 1'b0, 16'(16'h4000 + k));
      tick();
    end
    clear_writes();
    check_output("full no lost", 32'(bus.LOST), 32'h0);
    apply_stimulus(4, 1'b0, 16'h40FF);
    bus.LOST_CLR = 1'b1;
    tick();
    clear_writes();
    bus.LOST_CLR = 1'b0;
    check_output("clr vs ovf lost", 32'(bus.LOST), 32'h10);
`ifdef M26_RX_ARBITER_LOST_CNT_EN
    check_output("clr vs ovf cnt", 32'(bus.LOST_CNT[39:32]), 32'd1);
`endif

    // Asynchronous reset in the middle of draining ch4
    bus.FIFO_FULL = 1'b0;
    tick();
    expect_word("rst pre w0", word_of(4, 1'b0, 16'h4000));
    tick();
    expect_word("rst pre w1", word_of(4, 1'b0, 16'h4001));
    #2 rst_n = 1'b0;
    #1;
    expect_idle("rst async");
    check_output("rst async data", bus.FIFO_DATA, 32'h0);
    check_output("rst async lost", 32'(bus.LOST), 32'h0);
    #2 rst_n = 1'b1;
    apply_stimulus(5, 1'b0, 16'h5555);
    apply_stimulus(1, 1'b0, 16'h1111);
    apply_stimulus(0, 1'b0, 16'h0AAA);
    tick();
    clear_writes();
    expect_idle("post rst first");
    tick();
    expect_word("post rst ch0", word_of(0, 1'b0, 16'h0AAA));
    tick();
    expect_word("post rst ch1", word_of(1, 1'b0, 16'h1111));
    tick();
    expect_word("post rst ch5", word_of(5, 1'b0, 16'h5555));
    tick();
    expect_idle("post rst end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m26_rx_arbiter.md
Name: m26_rx_arbiter

Overview:
- Merges the WRITE/FRAME_START/DATA streams of NUM_CH Mimosa26 receive channels into one tagged 32-bit word stream for the shared readout FIFO.
- Each channel gets a small elastic buffer.
- A round-robin scheduler drains the buffers one word per cycle.
- Per-channel overflow handling discards the remainder of a corrupted frame, so the readout never sees a truncated frame without a marker.

Parameters:
- NUM_CH, 6: number of receive channels (1..16).
- DEPTH, 8: per-channel buffer depth in words (power of two, >=4).
- HEADER, 8'h20: constant placed in output bits [31:24].

Ports:
- CLK_RX  in  1  receive clock; everything is synchronous to it.
- RST_N  in  1  asynchronous, active-low reset.
- CH_ENABLE  in  NUM_CH  per-channel accept enable.
- CH_WRITE  in  NUM_CH  per-channel word strobe.
- CH_FRAME_START  in  NUM_CH  per-channel frame-start flag, qualified by CH_WRITE.
- CH_DATA  in  16*NUM_CH  per-channel data; channel i occupies bits [16*i+15:16*i].
- FIFO_FULL  in  1  downstream almost-full; at least 1 free entry remains when asserted.
- FIFO_WRITE  out  1  output word valid.
- FIFO_DATA  out  32  output word.
- LOST  out  NUM_CH  sticky per-channel overflow flag.
- LOST_CLR  in  1  clears LOST and the lost counters.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - FIFO_WRITE=0, FIFO_DATA=0, LOST=0.
  - All buffers empty, all channel states ACCEPT.
  - Round-robin pointer = NUM_CH-1, so channel 0 is favoured first.
- Output word format:
  - [31:24]=HEADER, [23:20]=channel id, [19:17]=0, [16]=frame start, [15:0]=data.
- Ingest, per channel i, each cycle with CH_WRITE[i]=1 and CH_ENABLE[i]=1:
  - ACCEPT, buffer not full: push {FRAME_START,DATA}.
  - ACCEPT, buffer full: drop the word; set LOST[i]; lost counter +1 (8 bit, saturating); go to DISCARD.
  - DISCARD, FRAME_START=0: drop the word; no counter change.
  - DISCARD, FRAME_START=1, buffer not full: push the word and go to ACCEPT.
  - DISCARD, FRAME_START=1, buffer full: drop the word, lost counter +1, stay in DISCARD.
  - CH_ENABLE[i]=0: input ignored and state unchanged. Words already buffered still drain.
- Full is evaluated before the same-cycle pop, so push and pop in one cycle is allowed only when the buffer is not full.
- Scheduler:
  - In cycle t, if FIFO_FULL=0 and any buffer is non-empty, grant the first non-empty channel searching from pointer+1 with wrap-around.
  - Pop one word from the granted buffer; pointer := granted channel.
  - If FIFO_FULL=1 or all buffers are empty: no grant, pointer holds.
  - An empty buffer is never popped.
- Latency:
  - The granted word is registered and appears with FIFO_WRITE=1 in cycle t+1; FIFO_WRITE=0 otherwise.
  - FIFO_DATA holds its last value while FIFO_WRITE=0.
  - Minimum path: CH_WRITE at t -> buffer at t+1 -> grant at t+1 -> FIFO_WRITE at t+2.
  - Sustained throughput is 1 word/cycle total.
- Fairness: with all channels continuously non-empty, grant order is 0,1,...,NUM_CH-1,0,...
- LOST_CLR=1 clears LOST and the counters in that cycle. A same-cycle overflow event wins: LOST bit set, counter=1.
- Reset mid-frame: buffered words are lost. After reset every channel is in ACCEPT; the first accepted word is not required to be a frame start.

Optional Feature:
- Macro: M26_RX_ARBITER_LOST_CNT_EN.
- Defined:
  - Adds output port LOST_CNT (8*NUM_CH bits) carrying the per-channel saturating counters.
  - On DISCARD->ACCEPT, the frame-start word is emitted with bits [19:17]=3'b111 as a resync marker.
- Undefined:
  - No counters are built and no LOST_CNT port exists.
  - Bits [19:17] are always 0.
  - LOST flags and DISCARD behaviour are unchanged.

Decomposition:
- Package m26_rx_pkg holds:
  - M26_HEADER_DEFAULT.
  - Word field offsets: CH_ID_LSB=20, FS_BIT=16, RESYNC_LSB=17.
  - Channel state enum (ACCEPT, DISCARD).
- Sub-module m26_rx_arb_buf: per-channel synchronous FIFO, 17 bits wide, DEPTH deep, with push/pop/full/empty/dout. Instantiated NUM_CH times.

Test Plan:
1. Single-channel frame: ch0 writes 4 words 0xAAAA(FS),0x0001,0x0002,0x0003 on consecutive cycles -> FIFO_DATA=0x2001AAAA, 0x20000001, 0x20000002, 0x20000003, first valid 2 cycles after the first CH_WRITE.
2. Round-robin: channels 0,1,2 each preloaded with 3 words, FIFO_FULL=0 -> channel order 0,1,2,0,1,2,0,1,2 with no idle cycles.
3. Backpressure: FIFO_FULL held high 5 cycles while ch1 has data -> at most 1 FIFO_WRITE after FULL rises. Draining resumes 1 cycle after FULL falls; no word is lost or duplicated.
4. Overflow: FIFO_FULL=1, ch0 writes DEPTH+3 words, then FS=1 word 0xBEEF after release -> exactly DEPTH words emitted, LOST[0]=1, next emitted ch0 word is 0x2001BEEF (0x200FBEEF with the macro), LOST_CNT[7:0]=1.
5. Enable and clear: CH_ENABLE[2]=0 during writes -> no ch2 output. LOST_CLR pulse -> LOST=0 on the next cycle.
6. Async reset: RST_N low mid-transfer -> FIFO_WRITE=0 immediately. After release, channel 0 wins the first contention.
